// File: rtl/dmem_store_buffer_if.sv
// Store-buffer bundle: MEM-stage store/load lookup, commit slot, and data-memory write port.
interface dmem_store_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              commit_slot;
   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic [3:0]        st_be;
   logic [ADDR_W-1:0] ld_addr;
   logic [3:0]        fwd_mask;
   logic [DATA_W-1:0] fwd_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              sb_empty;
   logic [CNT_W-1:0]  sb_count;

   modport master (
      output commit_slot, st_valid, st_addr, st_data, st_be, ld_addr,
      input  st_ready, fwd_mask, fwd_data, mem_we, mem_addr, mem_wdata, mem_be,
             sb_empty, sb_count
   );

   modport slave (
      input  commit_slot, st_valid, st_addr, st_data, st_be, ld_addr,
      output st_ready, fwd_mask, fwd_data, mem_we, mem_addr, mem_wdata, mem_be,
             sb_empty, sb_count
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store buffer: one store popped to registered mem_* per commit slot (>=1 cycle after accept),
// byte-forwards to loads; st_ready drops while full, even when a pop happens the same cycle.
module dmem_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   dmem_store_buffer_if.slave sb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   logic [WA_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [3:0]        be_q   [DEPTH];

   logic [DEPTH-1:0]  vld_q, vld_d;
   ptr_t              head_q, head_d;
   ptr_t              tail_q, tail_d;
   cnt_t              count_q, count_d;

   logic              mem_we_q, mem_we_d;
   logic [WA_W-1:0]   mem_wa_q, mem_wa_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;

   logic              push;
   logic              pop;
   logic [WA_W-1:0]   ld_wa;
   ptr_t              idx;
   logic [3:0]        fwd_mask_c;
   logic [DATA_W-1:0] fwd_data_c;

   assign sb.st_ready = (count_q < cnt_t'(DEPTH));
   assign push        = sb.st_valid & sb.st_ready;
   assign pop         = sb.commit_slot & (count_q != '0);

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      vld_d       = vld_q;
      mem_we_d    = 1'b0;
      mem_wa_d    = mem_wa_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;

      if (push) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + ptr_t'(1);
      end

      // Push and pop never target the same slot: that would need count==0 and count==DEPTH at once.
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + ptr_t'(1);
         mem_we_d      = 1'b1;
         mem_wa_d      = addr_q[head_q];
         mem_wdata_d   = data_q[head_q];
         mem_be_d      = be_q[head_q];
      end

      case ({push, pop})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         vld_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_wa_q    <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         vld_q       <= vld_d;
         mem_we_q    <= mem_we_d;
         mem_wa_q    <= mem_wa_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
      end
   end

   // Entry payload is qualified by vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= sb.st_addr[ADDR_W-1:2];
         data_q[tail_q] <= sb.st_data;
         be_q[tail_q]   <= sb.st_be;
      end
   end

   // Walk oldest to youngest (output register, then head..tail-1) so younger lanes overwrite older ones.
   always_comb begin
      fwd_mask_c = '0;
      fwd_data_c = '0;
      idx        = '0;
      ld_wa      = sb.ld_addr[ADDR_W-1:2];

      if (mem_we_q && (mem_wa_q == ld_wa)) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be_q[b]) begin
               fwd_mask_c[b]        = 1'b1;
               fwd_data_c[8*b +: 8] = mem_wdata_q[8*b +: 8];
            end
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + ptr_t'(i);
         if (vld_q[idx] && (addr_q[idx] == ld_wa)) begin
            for (int b = 0; b < 4; b++) begin
               if (be_q[idx][b]) begin
                  fwd_mask_c[b]        = 1'b1;
                  fwd_data_c[8*b +: 8] = data_q[idx][8*b +: 8];
               end
            end
         end
      end
   end

   assign sb.fwd_mask  = fwd_mask_c;
   assign sb.fwd_data  = fwd_data_c;
   assign sb.mem_we    = mem_we_q;
   assign sb.mem_addr  = {mem_wa_q, 2'b00};
   assign sb.mem_wdata = mem_wdata_q;
   assign sb.mem_be    = mem_be_q;
   assign sb.sb_empty  = (count_q == '0) & ~mem_we_q;
   assign sb.sb_count  = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: accepted stores queue expected commits, mem_we pops and compares.
module tb_dmem_store_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic done;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   dmem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

   dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pop expected commit on each mem_we pulse; record accepted stores (sampled mid-cycle, before their edge).
   always @(negedge clk) begin
      if (rst) begin
         if (sb_if.mem_we) begin
            if (exp_q.size() == 0) begin
               check("commit_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("commit_addr", sb_if.mem_addr, mon_e.addr);
               check("commit_data", sb_if.mem_wdata, mon_e.data);
               check("commit_be", sb_if.mem_be, mon_e.be);
            end
         end
         if (sb_if.st_valid && sb_if.st_ready)
            exp_q.push_back('{addr: {sb_if.st_addr[31:2], 2'b00}, data: sb_if.st_data, be: sb_if.st_be});
      end
   end

   task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      n = 0;
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = a;
      sb_if.st_data  = d;
      sb_if.st_be    = be;
      @(negedge clk);
      while (!sb_if.st_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("enq_timeout", 0, 1);
      @(posedge clk);
      #1;
      sb_if.st_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      sb_if.commit_slot = 1'b1;
      @(negedge clk);
      while (!sb_if.sb_empty && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
      sb_if.commit_slot = 1'b0;
   endtask

   initial begin
      done              = 1'b0;
      sb_if.commit_slot = 1'b0;
      sb_if.st_valid    = 1'b0;
      sb_if.st_addr     = '0;
      sb_if.st_data     = '0;
      sb_if.st_be       = '0;
      sb_if.ld_addr     = '0;

      // Power-on reset state
      #3;
      check("rst_mem_we", sb_if.mem_we, 0);
      check("rst_count", sb_if.sb_count, 0);
      check("rst_empty", sb_if.sb_empty, 1);
      check("rst_ready", sb_if.st_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Fill and drain
      for (int i = 0; i < 4; i++) enq(32'(4 * i), 32'h11111111 * 32'(i + 1), 4'b1111);
      @(negedge clk);
      check("full_ready", sb_if.st_ready, 0);
      check("full_count", sb_if.sb_count, 4);
      check("full_no_we", sb_if.mem_we, 0);
      @(posedge clk);
      #1;
      sb_if.commit_slot = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("drain_we", sb_if.mem_we, 1);
         check("drain_count", sb_if.sb_count, 32'(3 - i));
      end
      check("drain_inflight_not_empty", sb_if.sb_empty, 0);
      @(negedge clk);
      check("drain_we_pulse_end", sb_if.mem_we, 0);
      check("drain_empty", sb_if.sb_empty, 1);
      check("hold_addr", sb_if.mem_addr, 32'h0C);
      check("hold_data", sb_if.mem_wdata, 32'h44444444);
      @(posedge clk);
      #1;
      sb_if.commit_slot = 1'b0;

      // Full with simultaneous pop: store waits one edge
      for (int i = 0; i < 4; i++) enq(32'h40 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'b0101);
      sb_if.st_valid    = 1'b1;
      sb_if.st_addr     = 32'h50;
      sb_if.st_data     = 32'h5555AAAA;
      sb_if.st_be       = 4'b1111;
      sb_if.commit_slot = 1'b1;
      @(negedge clk);
      check("fp_ready_full", sb_if.st_ready, 0);
      check("fp_count4", sb_if.sb_count, 4);
      @(negedge clk);
      check("fp_count3", sb_if.sb_count, 3);
      check("fp_ready", sb_if.st_ready, 1);
      check("fp_we", sb_if.mem_we, 1);
      @(posedge clk);
      #1;
      sb_if.st_valid = 1'b0;
      @(negedge clk);
      check("fp_count_push_pop", sb_if.sb_count, 3);
      drain();

      // Forwarding merge, youngest lane wins
      enq(32'h100, 32'hAABBCCDD, 4'b0011);
      enq(32'h102, 32'h11223344, 4'b1100);
      sb_if.ld_addr = 32'h100;
      #1;
      check("fwd_mask_merge", sb_if.fwd_mask, 4'b1111);
      check("fwd_data_merge", sb_if.fwd_data, 32'h1122CCDD);
      enq(32'h100, 32'h000000EE, 4'b0001);
      #1;
      check("fwd_mask_young", sb_if.fwd_mask, 4'b1111);
      check("fwd_data_young", sb_if.fwd_data, 32'h1122CCEE);
      sb_if.ld_addr = 32'h104;
      #1;
      check("fwd_mask_miss", sb_if.fwd_mask, 4'b0000);
      check("fwd_data_miss", sb_if.fwd_data, 32'h0);
      drain();

      // In-flight forwarding from the output register
      enq(32'h200, 32'hDEADBEEF, 4'b1111);
      sb_if.ld_addr     = 32'h200;
      sb_if.commit_slot = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("inflight_we", sb_if.mem_we, 1);
      check("inflight_mask", sb_if.fwd_mask, 4'b1111);
      check("inflight_data", sb_if.fwd_data, 32'hDEADBEEF);
      sb_if.commit_slot = 1'b0;
      @(negedge clk);
      check("after_we", sb_if.mem_we, 0);
      check("after_mask", sb_if.fwd_mask, 4'b0000);
      @(posedge clk);
      #1;

      // Wrap-around with toggling commit slot
      fork
         begin
            for (int i = 0; i < 10; i++)
               enq(32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'(i + 1));
            done = 1'b1;
         end
         begin
            int n;
            n = 0;
            while (!(done && sb_if.sb_empty) && n < 300) begin
               @(posedge clk);
               #1;
               sb_if.commit_slot = ~sb_if.commit_slot;
               @(negedge clk);
               check("wrap_count_le_depth", sb_if.sb_count <= 4, 1);
               n++;
            end
            if (n >= 300) check("wrap_timeout", 0, 1);
         end
      join
      @(posedge clk);
      #1;
      sb_if.commit_slot = 1'b0;
      check("wrap_all_committed", exp_q.size(), 0);

      // Reset mid-traffic: count=3 with a write in flight
      for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), 32'h77770000 + 32'(i), 4'b1111);
      sb_if.commit_slot = 1'b1;
      @(posedge clk);
      #2;
      check("pre_rst_count", sb_if.sb_count, 3);
      check("pre_rst_we", sb_if.mem_we, 1);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_we", sb_if.mem_we, 0);
      check("mid_rst_addr", sb_if.mem_addr, 0);
      check("mid_rst_data", sb_if.mem_wdata, 0);
      check("mid_rst_be", sb_if.mem_be, 0);
      check("mid_rst_count", sb_if.sb_count, 0);
      check("mid_rst_empty", sb_if.sb_empty, 1);
      check("mid_rst_ready", sb_if.st_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_we", sb_if.mem_we, 0);
         check("post_rst_empty", sb_if.sb_empty, 1);
      end
      sb_if.commit_slot = 1'b0;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Small in-order store buffer between the MEM stage and the data memory write port of the pipeline CPU.
- The data memory commits writes on the inverted-phase clock. This block queues stores from the MEM stage and releases one per commit slot.
- The commit slot comes from the falling-edge detector output, already registered into the clk domain.
- It also byte-forwards buffered store data to same-cycle loads, so loads never read stale memory.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, ≥2).
- ADDR_W, 32, byte-address width; the low 2 bits are ignored (word-aligned storage).
- DATA_W, 32, data width (fixed at 32; byte-enables are 4 bits).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- commit_slot  in  1  commit permission for the current cycle; sampled at the rising edge.
- st_valid  in  1  MEM-stage store request.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data, byte-lane aligned.
- st_be  in  4  store byte enables.
- ld_addr  in  ADDR_W  MEM-stage load address, for forwarding lookup.
- fwd_mask  out  4  lanes supplied by forwarding (combinational).
- fwd_data  out  DATA_W  forwarded bytes; lanes not set in fwd_mask read 0.
- mem_we  out  1  data memory write enable (registered).
- mem_addr  out  ADDR_W  registered write address, low 2 bits forced to 0.
- mem_wdata  out  DATA_W  registered write data.
- mem_be  out  4  registered write byte enables.
- sb_empty  out  1  no entries held and no write in flight (used for fences and halt).
- sb_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Reset (rst=0, asynchronous) clears all of the following to 0 immediately:
  - count, pointers and entry valid bits;
  - mem_we, mem_addr, mem_wdata, mem_be.
  - After reset, sb_empty=1 and st_ready=1.
  - Reset mid-operation discards all pending stores. No partial write is issued.
- st_ready = (count < DEPTH). It is deliberately not relaxed by a same-cycle pop when full.
- Enqueue: on a rising edge with st_valid & st_ready, write {addr, data, be} at tail; tail++, count++.
  - st_be=0 is still enqueued and committed as a no-op write.
- Commit/pop: on a rising edge with commit_slot=1 and count>0, pop the head into the mem_* output registers and set mem_we=1; head++, count--.
  - Otherwise mem_we=0 on that edge; mem_addr, mem_wdata and mem_be hold their values.
  - mem_we is therefore a one-cycle pulse per commit.
- Simultaneous enqueue and pop: both occur; count is unchanged.
  - When count=0, a store cannot be enqueued and committed on the same edge. The earliest commit is the next slot edge.
- Latency: a store accepted at edge N drives mem_we high, at the earliest, in the cycle after edge N+1 (needs commit_slot=1 at N+1).
- Forwarding (combinational): word-address compare, ld_addr[ADDR_W-1:2] against each source.
  - Sources are all valid entries plus the in-flight output register (while mem_we=1).
  - For each byte lane, take the youngest matching source whose be has that lane set. Age order, youngest first: buffer tail-1 … head, then the output register.
  - fwd_mask[i]=1 if any source supplied lane i.
  - The load stage merges fwd_data over memory read data for masked lanes.
- sb_empty = (count==0) & ~mem_we.
- Arithmetic: count never exceeds DEPTH and never underflows. A pop with count=0 is ignored.
- commit_slot held high continuously: drains one entry per cycle.
- commit_slot low: the buffer only fills; stores stall via st_ready=0 once full.

Test Plan:
1. Reset release: assert rst=0 mid-traffic with count=3 and mem_we=1 → all outputs 0 immediately, sb_empty=1, st_ready=1; no mem_we follows after rst=1.
2. Fill and drain: commit_slot=0; enqueue 4 stores to addresses 0x00/0x04/0x08/0x0C, data 0x11111111..0x44444444 → st_ready=0, sb_count=4. Then commit_slot=1 → four consecutive mem_we pulses in FIFO order with matching addr/data/be; sb_empty=1 after the last.
3. Full with simultaneous pop: count=4, st_valid=1, commit_slot=1 → the store is not accepted that edge, count goes to 3; the store is accepted the next edge.
4. Forwarding merge: enqueue 0x100 data 0xAABBCCDD be=0011, then 0x102 data 0x11223344 be=1100; ld_addr=0x100 → fwd_mask=1111, fwd_data=0x1122CCDD. Then enqueue 0x100 be=0001 data 0x000000EE → fwd_data=0x1122CCEE.
5. In-flight forwarding: the single entry at 0x200 be=1111 data 0xDEADBEEF is committed (mem_we=1) while ld_addr=0x200 → fwd_mask=1111, fwd_data=0xDEADBEEF. The next cycle (mem_we=0) → fwd_mask=0000.
6. Wrap-around: with commit_slot toggling 1,0,1,0, stream 10 stores → pointers wrap twice, the commit sequence matches enqueue order exactly, and sb_count never exceeds 4.
